// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_io_ctrl
//  Purpose  : Memory-mapped IO controller. Holds the LED and 7-segment
//             registers and a buffered UART path (TX FIFO drains into
//             txuart through a small FSM, RX FIFO fills from rxuart).
//             Registers are decoded by one-hot word-address bits; when
//             several bits are set the lowest one wins.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             io_sel, word_addr    - IO space select, one-hot register select
//             wdata, wmask, rstrb  - write data, byte enables, read strobe
//             rdata                - combinational read data
//             leds, sseg           - LED and 7-segment registers
//             tx_wr, tx_data       - one-cycle byte hand-off to txuart
//             tx_busy              - txuart busy
//             rx_valid, rx_data    - byte strobe from rxuart
//             irq                  - interrupt (only with IO_IRQ_EN)
//  Options  : define IO_IRQ_EN to add the irq port and the ie register.
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl #(
    parameter int LED_W    = 16,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_sel,
    input  logic [3:0]       word_addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wmask,
    input  logic             rstrb,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] leds,
    output logic [31:0]      sseg,
    output logic             tx_wr,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data
`ifdef IO_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ISSUE = 2'd1,
        TX_HOLD  = 2'd2
    } tx_state_t;

    // Lowest set address bit wins.
    logic sel_led, sel_dat, sel_ctrl, sel_sseg, wr_en;
    assign sel_led  = word_addr[0];
    assign sel_dat  = word_addr[1] & ~word_addr[0];
    assign sel_ctrl = word_addr[2] & ~|word_addr[1:0];
    assign sel_sseg = word_addr[3] & ~|word_addr[2:0];
    assign wr_en    = io_sel & |wmask;

    // FIFO storage and pointers (one extra bit to tell full from empty).
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr, tx_diff;
    logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr, rx_diff;
    logic           tx_empty, tx_full, rx_ne, rx_full;
    logic           tx_push, tx_pop, rx_push, rx_pop;
    logic           tx_ovf, rx_ovf;
    logic [8:0]     tx_cnt9, rx_cnt9;
    logic [7:0]     tx_count, rx_count, rx_head;
    logic [1:0]     ie;
    tx_state_t      tx_state;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                      (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    assign rx_ne    = (rx_wr_ptr != rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                      (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);

    assign tx_diff  = tx_wr_ptr - tx_rd_ptr;
    assign rx_diff  = rx_wr_ptr - rx_rd_ptr;
    assign tx_cnt9  = 9'(tx_diff);
    assign rx_cnt9  = 9'(rx_diff);
    // A 256-deep FIFO that is full would need 9 bits; report 255 instead.
    assign tx_count = tx_cnt9[8] ? 8'hFF : tx_cnt9[7:0];
    assign rx_count = rx_cnt9[8] ? 8'hFF : rx_cnt9[7:0];
    assign rx_head  = rx_mem[rx_rd_ptr[RX_AW-1:0]];

    assign tx_push  = wr_en & sel_dat & ~tx_full;
    // The FIFO head is handed over on the edge that leaves IDLE.
    assign tx_pop   = (tx_state == TX_IDLE) & ~tx_empty & ~tx_busy;
    assign rx_pop   = io_sel & rstrb & sel_dat & rx_ne;
    // A full RX FIFO still accepts a byte when a pop frees a slot that edge.
    assign rx_push  = rx_valid & (~rx_full | rx_pop);

    // Read mux
    always_comb begin
        rdata = 32'h0;
        if (io_sel) begin
            if (sel_led) begin
                rdata = 32'(leds);
            end else if (sel_dat) begin
                rdata = rx_ne ? {23'h0, 1'b1, rx_head} : 32'h0;
            end else if (sel_ctrl) begin
                rdata = {tx_count, rx_count, 3'b000, tx_ovf, rx_ovf,
                         tx_empty, tx_full, rx_ne, 6'b000000, ie};
            end else if (sel_sseg) begin
                rdata = sseg;
            end
        end
    end

    // FIFO data arrays (no reset needed; validity is tracked by pointers)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= wdata[7:0];
        if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_data;
    end

    // Registers, pointers and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            leds      <= '0;
            sseg      <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
        end else begin
            if (wr_en && sel_led) begin
                for (int i = 0; i < LED_W; i++) begin
                    if (wmask[i/8]) leds[i] <= wdata[i];
                end
            end
            if (wr_en && sel_sseg) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) sseg[8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            // Set has priority over a write-one-to-clear in the same cycle.
            if (wr_en && sel_dat && tx_full)        tx_ovf <= 1'b1;
            else if (wr_en && sel_ctrl && wdata[12]) tx_ovf <= 1'b0;
            if (rx_valid && rx_full && !rx_pop)      rx_ovf <= 1'b1;
            else if (wr_en && sel_ctrl && wdata[11]) rx_ovf <= 1'b0;
        end
    end

    // TX FSM: IDLE -> ISSUE (tx_wr high) -> HOLD -> IDLE, 3 cycles per byte.
    // HOLD gives txuart one cycle to raise tx_busy before IDLE looks again.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_wr    <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_wr <= 1'b0;
                    if (tx_pop) begin
                        tx_state <= TX_ISSUE;
                        tx_wr    <= 1'b1;
                        tx_data  <= tx_mem[tx_rd_ptr[TX_AW-1:0]];
                    end
                end
                TX_ISSUE: begin
                    tx_wr    <= 1'b0;
                    tx_state <= TX_HOLD;
                end
                TX_HOLD: begin
                    tx_wr    <= 1'b0;
                    tx_state <= TX_IDLE;
                end
                default: begin
                    tx_wr    <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef IO_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ie  <= 2'b00;
            irq <= 1'b0;
        end else begin
            if (wr_en && sel_ctrl) ie <= wdata[1:0];
            irq <= (ie[0] & rx_ne) | (ie[1] & tx_empty) | rx_ovf;
        end
    end
`else
    assign ie = 2'b00;
`endif

endmodule
`default_nettype wire
